// File: rtl/trace_axis_downsizer.sv
// Splits each wide {pc, instr} trace item into BEATS narrow AXI-Stream beats, LSB slice first.
// States: EMPTY | no item held, ready for input;  SENDING | emitting beats of hold_data
module trace_axis_downsizer #(
  parameter int IN_WIDTH  = 96,
  parameter int OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 S_AXIS_tvalid,
  output logic                 S_AXIS_tready,
  input  logic [IN_WIDTH-1:0]  S_AXIS_tdata,
  input  logic                 S_AXIS_tlast,
  output logic                 M_AXIS_tvalid,
  input  logic                 M_AXIS_tready,
  output logic [OUT_WIDTH-1:0] M_AXIS_tdata,
  output logic                 M_AXIS_tlast,
  output logic [31:0]          items_sent,
  output logic [31:0]          stall_cycles
);

  localparam int BEATS = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {EMPTY, SENDING} state_t;

  state_t              state_q, state_d;
  logic [IN_WIDTH-1:0] hold_data;
  logic                hold_last;
  logic [IDX_W-1:0]    idx, idx_d;
  logic                last_beat;
  logic                load;
  logic                m_hs;

  assign last_beat     = (idx == IDX_W'(BEATS - 1));
  assign M_AXIS_tvalid = (state_q == SENDING);
  assign M_AXIS_tlast  = (state_q == SENDING) & hold_last & last_beat;
  assign m_hs          = M_AXIS_tvalid & M_AXIS_tready;
  // Ready never looks at S_AXIS_tvalid, so upstream cannot form a combinational loop through us.
  assign S_AXIS_tready = ~rst & ((state_q == EMPTY) |
                                 ((state_q == SENDING) & last_beat & M_AXIS_tready));

  always_comb begin
    M_AXIS_tdata = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (idx == IDX_W'(b)) M_AXIS_tdata = hold_data[b*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx;
    load    = 1'b0;
    case (state_q)
      EMPTY: begin
        if (S_AXIS_tvalid) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = SENDING;
        end
      end
      SENDING: begin
        if (m_hs) begin
          if (!last_beat) begin
            idx_d = idx + IDX_W'(1);
          end else if (S_AXIS_tvalid) begin
            // Refill on the final beat so consecutive items stream without a bubble.
            load  = 1'b1;
            idx_d = '0;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      idx          <= '0;
      hold_data    <= '0;
      hold_last    <= 1'b0;
      items_sent   <= '0;
      stall_cycles <= '0;
    end else begin
      state_q <= state_d;
      idx     <= idx_d;
      if (load) begin
        hold_data <= S_AXIS_tdata;
        hold_last <= S_AXIS_tlast;
      end
      if (m_hs && last_beat) items_sent <= items_sent + 32'd1;
      if (M_AXIS_tvalid && !M_AXIS_tready && stall_cycles != 32'hFFFF_FFFF)
        stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_trace_axis_downsizer.sv
// Directed bench for trace_axis_downsizer (96-bit items to 32-bit beats).
module tb_trace_axis_downsizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_tvalid, s_tready, s_tlast;
  logic [95:0] s_tdata;
  logic        m_tvalid, m_tready, m_tlast;
  logic [31:0] m_tdata;
  logic [31:0] items_sent, stall_cycles;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  trace_axis_downsizer #(.IN_WIDTH(96), .OUT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .S_AXIS_tvalid(s_tvalid), .S_AXIS_tready(s_tready),
    .S_AXIS_tdata(s_tdata), .S_AXIS_tlast(s_tlast),
    .M_AXIS_tvalid(m_tvalid), .M_AXIS_tready(m_tready),
    .M_AXIS_tdata(m_tdata), .M_AXIS_tlast(m_tlast),
    .items_sent(items_sent), .stall_cycles(stall_cycles)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b1;
    step();
    step();
    #1;
    vecs++;
    if (m_tvalid !== 1'b0 || m_tdata !== 32'h0 || m_tlast !== 1'b0)
      begin errs++; $display("FAIL reset_m_out: got v=%b d=%h l=%b want 0/0/0", m_tvalid, m_tdata, m_tlast); end
    vecs++;
    if (items_sent !== 32'h0 || stall_cycles !== 32'h0)
      begin errs++; $display("FAIL reset_counters: got items=%h stall=%h want 0/0", items_sent, stall_cycles); end
    vecs++;
    if (s_tready !== 1'b0) begin errs++; $display("FAIL reset_s_tready: got %b want 0", s_tready); end
    rst = 1'b0;
    #1;
    vecs++;
    if (s_tready !== 1'b1) begin errs++; $display("FAIL release_s_tready: got %b want 1", s_tready); end
  endtask

  task automatic test_single_item();
    logic [31:0] exp_beat [3];
    exp_beat[0] = 32'h0000_0013; exp_beat[1] = 32'h8000_0004; exp_beat[2] = 32'h0000_0000;
    do_reset();
    s_tvalid = 1'b1; s_tdata = {64'h0000_0000_8000_0004, 32'h0000_0013}; s_tlast = 1'b1;
    step();
    s_tvalid = 1'b0;
    #1;
    for (int b = 0; b < 3; b++) begin
      vecs++;
      if (m_tvalid !== 1'b1 || m_tdata !== exp_beat[b] || m_tlast !== (b == 2))
        begin errs++; $display("FAIL single_beat%0d: got v=%b d=%h l=%b want 1/%h/%b", b, m_tvalid, m_tdata, m_tlast, exp_beat[b], (b == 2)); end
      step();
    end
    vecs++;
    if (m_tvalid !== 1'b0 || items_sent !== 32'd1 || stall_cycles !== 32'd0)
      begin errs++; $display("FAIL single_done: got v=%b items=%0d stall=%0d want 0/1/0", m_tvalid, items_sent, stall_cycles); end
  endtask

  task automatic test_back_to_back();
    logic [95:0] items [4];
    int k;
    logic exp_rdy;
    for (int i = 0; i < 4; i++)
      items[i] = {32'hA000_0000 + 32'(i), 32'h0000_1000 + 32'(4 * i), 32'hC0DE_0000 + 32'(i)};
    do_reset();
    k = 0;
    for (int c = 0; c <= 12; c++) begin
      s_tvalid = (k < 4); s_tdata = (k < 4) ? items[k] : '0; s_tlast = 1'b0;
      #1;
      exp_rdy = (c % 3 == 0);
      vecs++;
      if (s_tready !== exp_rdy) begin errs++; $display("FAIL b2b_s_tready c%0d: got %b want %b", c, s_tready, exp_rdy); end
      if (c >= 1) begin
        vecs++;
        if (m_tvalid !== 1'b1 || m_tdata !== items[(c-1)/3][((c-1)%3)*32 +: 32])
          begin errs++; $display("FAIL b2b_beat c%0d: got v=%b d=%h want 1/%h", c, m_tvalid, m_tdata, items[(c-1)/3][((c-1)%3)*32 +: 32]); end
      end
      if (exp_rdy && k < 4) k++;
      step();
    end
    s_tvalid = 1'b0;
    #1;
    vecs++;
    if (m_tvalid !== 1'b0 || items_sent !== 32'd4)
      begin errs++; $display("FAIL b2b_done: got v=%b items=%0d want 0/4", m_tvalid, items_sent); end
  endtask

  task automatic test_back_pressure();
    do_reset();
    s_tvalid = 1'b1; s_tdata = {64'h1111_2222_3333_4444, 32'h5555_6666}; s_tlast = 1'b1;
    step();
    s_tvalid = 1'b0;
    #1;
    vecs++;
    if (m_tdata !== 32'h5555_6666) begin errs++; $display("FAIL bp_beat0: got %h want 55556666", m_tdata); end
    step();
    for (int i = 0; i < 5; i++) begin
      m_tready = 1'b0;
      #1;
      vecs++;
      if (m_tvalid !== 1'b1 || m_tdata !== 32'h3333_4444 || m_tlast !== 1'b0 || s_tready !== 1'b0)
        begin errs++; $display("FAIL bp_hold%0d: got v=%b d=%h l=%b srdy=%b want 1/33334444/0/0", i, m_tvalid, m_tdata, m_tlast, s_tready); end
      step();
    end
    m_tready = 1'b1;
    #1;
    vecs++;
    if (m_tdata !== 32'h3333_4444) begin errs++; $display("FAIL bp_resume1: got %h want 33334444", m_tdata); end
    step();
    vecs++;
    if (m_tdata !== 32'h1111_2222 || m_tlast !== 1'b1)
      begin errs++; $display("FAIL bp_beat2: got d=%h l=%b want 11112222/1", m_tdata, m_tlast); end
    step();
    vecs++;
    if (m_tvalid !== 1'b0 || stall_cycles !== 32'd5 || items_sent !== 32'd1)
      begin errs++; $display("FAIL bp_done: got v=%b stall=%0d items=%0d want 0/5/1", m_tvalid, stall_cycles, items_sent); end
  endtask

  task automatic test_tlast_routing();
    logic [2:0] pattern;
    int k;
    pattern = 3'b100;
    do_reset();
    k = 0;
    for (int c = 0; c <= 9; c++) begin
      s_tvalid = (k < 3); s_tdata = {32'hBEEF_0000 + 32'(k), 64'h0}; s_tlast = (k < 3) ? pattern[k] : 1'b0;
      #1;
      if (c >= 1) begin
        vecs++;
        if (m_tvalid !== 1'b1 || m_tlast !== (c == 9))
          begin errs++; $display("FAIL tlast_c%0d: got v=%b l=%b want 1/%b", c, m_tvalid, m_tlast, (c == 9)); end
      end
      if (c % 3 == 0 && k < 3) k++;
      step();
    end
    s_tvalid = 1'b0;
  endtask

  task automatic test_reset_mid_item();
    do_reset();
    s_tvalid = 1'b1; s_tdata = {64'hAAAA_AAAA_BBBB_BBBB, 32'hCCCC_CCCC}; s_tlast = 1'b1;
    step();
    s_tvalid = 1'b0;
    step(); step(); step();
    s_tvalid = 1'b1; s_tdata = {64'h0000_0002_0000_0001, 32'h0000_0000}; s_tlast = 1'b1;
    step();
    s_tvalid = 1'b0; m_tready = 1'b0;
    step();
    m_tready = 1'b1;
    step();
    vecs++;
    if (items_sent !== 32'd1 || stall_cycles !== 32'd1 || m_tdata !== 32'h0000_0001)
      begin errs++; $display("FAIL mid_pre: got items=%0d stall=%0d d=%h want 1/1/00000001", items_sent, stall_cycles, m_tdata); end
    rst = 1'b1;
    #1;
    vecs++;
    if (s_tready !== 1'b0) begin errs++; $display("FAIL mid_rst_s_tready: got %b want 0", s_tready); end
    step();
    rst = 1'b0;
    #1;
    vecs++;
    if (m_tvalid !== 1'b0 || m_tdata !== 32'h0 || m_tlast !== 1'b0 || items_sent !== 32'h0 || stall_cycles !== 32'h0)
      begin errs++; $display("FAIL mid_after_rst: got v=%b d=%h l=%b items=%0d stall=%0d want all 0", m_tvalid, m_tdata, m_tlast, items_sent, stall_cycles); end
    for (int i = 0; i < 3; i++) begin
      step();
      vecs++;
      if (m_tvalid !== 1'b0) begin errs++; $display("FAIL mid_no_beat%0d: got v=%b want 0", i, m_tvalid); end
    end
    s_tvalid = 1'b1; s_tdata = {64'h0000_00F2_0000_00F1, 32'h0000_00F0}; s_tlast = 1'b1;
    step();
    s_tvalid = 1'b0;
    #1;
    for (int b = 0; b < 3; b++) begin
      vecs++;
      if (m_tvalid !== 1'b1 || m_tdata !== 32'h0000_00F0 + 32'(b) || m_tlast !== (b == 2))
        begin errs++; $display("FAIL mid_next_beat%0d: got v=%b d=%h l=%b want 1/%h/%b", b, m_tvalid, m_tdata, m_tlast, 32'h0000_00F0 + 32'(b), (b == 2)); end
      step();
    end
  endtask

  task automatic test_saturation();
    do_reset();
    s_tvalid = 1'b1; s_tdata = {64'h0000_0007_0000_0006, 32'h0000_0005}; s_tlast = 1'b0;
    m_tready = 1'b0;
    step();
    s_tvalid = 1'b0;
    force dut.stall_cycles = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cycles;
    #1;
    vecs++;
    if (stall_cycles !== 32'hFFFF_FFFE) begin errs++; $display("FAIL sat_preload: got %h want fffffffe", stall_cycles); end
    for (int i = 0; i < 3; i++) begin
      step();
      vecs++;
      if (stall_cycles !== 32'hFFFF_FFFF) begin errs++; $display("FAIL sat_stall%0d: got %h want ffffffff", i, stall_cycles); end
    end
    force dut.items_sent = 32'hFFFF_FFFF;
    #1;
    release dut.items_sent;
    m_tready = 1'b1;
    step(); step(); step();
    vecs++;
    if (items_sent !== 32'h0 || m_tvalid !== 1'b0 || stall_cycles !== 32'hFFFF_FFFF)
      begin errs++; $display("FAIL sat_wrap: got items=%h v=%b stall=%h want 0/0/ffffffff", items_sent, m_tvalid, stall_cycles); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_item();
    test_back_to_back();
    test_back_pressure();
    test_tlast_routing();
    test_reset_mid_item();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/trace_axis_downsizer.md
# trace_axis_downsizer

Downstream stage of the trace FIFO path. Consumes the wide trace stream of {pc, instr} items, e.g. 96-bit (64-bit pc + 32-bit instr), and re-emits each item as BEATS narrow AXI-Stream beats, least-significant slice first, for the 32-bit DMA/host link. It preserves the packet boundary (tlast) and exposes item and back-pressure counters for link-bandwidth diagnosis.

## Interface
- IN_WIDTH, 96: input item width (XLEN + 32); must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 32: output beat width.
- BEATS (localparam) = IN_WIDTH / OUT_WIDTH; beat index width = clog2(BEATS), minimum 1.
- clk  in  1  sole clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- S_AXIS_tvalid  in  1  input item valid.
- S_AXIS_tready  out  1  input item accepted when tvalid & tready.
- S_AXIS_tdata  in  IN_WIDTH  item, {pc, instr}.
- S_AXIS_tlast  in  1  item closes a packet.
- M_AXIS_tvalid  out  1  output beat valid.
- M_AXIS_tready  in  1  downstream accepts beat.
- M_AXIS_tdata  out  OUT_WIDTH  current slice of the held item.
- M_AXIS_tlast  out  1  final beat of an item whose S_AXIS_tlast was set.
- items_sent  out  32  count of items fully emitted (last beat handshaken); wraps.
- stall_cycles  out  32  count of cycles with M_AXIS_tvalid & ~M_AXIS_tready; saturates at 0xFFFFFFFF.

## Operation
- State: hold_data[IN_WIDTH-1:0], hold_last, idx, FSM {EMPTY, SENDING}.
- EMPTY: M_AXIS_tvalid=0, S_AXIS_tready=1. On an input handshake: capture tdata/tlast, idx←0, go to SENDING.
- SENDING: M_AXIS_tvalid=1, M_AXIS_tdata = hold_data[idx*OUT_WIDTH +: OUT_WIDTH], M_AXIS_tlast = hold_last & (idx==BEATS-1).
  - Output handshake with idx<BEATS-1: idx←idx+1.
  - Output handshake with idx==BEATS-1: items_sent←items_sent+1. If S_AXIS_tvalid is high in the same cycle, load the new item, idx←0, stay in SENDING (no bubble). Otherwise go to EMPTY.
- S_AXIS_tready = ~rst & (state==EMPTY | (idx==BEATS-1 & M_AXIS_tready)). This is combinational from state and M_AXIS_tready only. It never depends on S_AXIS_tvalid.
- M_AXIS_tdata/tlast stay stable while tvalid=1 and tready=0 (AXIS rule). Once asserted, M_AXIS_tvalid does not drop before the handshake.
- For 96/32, beat order is instr, pc[31:0], pc[63:32].
- BEATS==1: degenerates to a registered pass-through with full throughput.
- stall_cycles increments on every cycle with M_AXIS_tvalid=1 and M_AXIS_tready=0, and holds once it reaches the maximum.
- Reset mid-item: the held item is discarded with no partial beats afterwards. State→EMPTY, idx, counters, and hold registers all →0.

## Timing
- Reset values after the edge with rst=1: M_AXIS_tvalid=0, M_AXIS_tdata=0, M_AXIS_tlast=0, items_sent=0, stall_cycles=0. S_AXIS_tready=0 while rst is high and 1 on the first cycle after release.
- Latency: an item accepted at edge N presents beat 0 on M from cycle N+1.
- Throughput: 1 output beat per cycle while M_AXIS_tready=1. Sustained input acceptance is 1 item per BEATS cycles.
- Simultaneous last-beat output handshake and input handshake: both complete in the same cycle and the new beat 0 appears the next cycle.
- Counter updates are visible the cycle after the causing edge.

## Test plan
- Single item: S_AXIS_tdata = pc 0x0000_0000_8000_0004, instr 0x0000_0013, tlast=1, with M_AXIS_tready=1 held. Required beats on cycles N+1..N+3: 0x00000013 (tlast=0), 0x80000004 (tlast=0), 0x00000000 (tlast=1). Then items_sent=1, stall_cycles=0.
- Back-to-back: 4 items presented with S_AXIS_tvalid held and tready=1. Required: 12 consecutive M beats with no gap, S_AXIS_tready high exactly every 3rd cycle, items_sent=4.
- Back-pressure: M_AXIS_tready=0 for 5 cycles in the middle of beat 1. Required: tdata and tlast stable, S_AXIS_tready=0 throughout, stall_cycles=5, correct beat order resumes.
- tlast routing: items with tlast pattern 0,0,1. Required: M_AXIS_tlast asserted only on beat 2 of item 3.
- Reset mid-item: assert rst for 1 cycle after beat 0 of an item. Required: no further beats of that item, all outputs 0, counters 0. The next item is emitted cleanly from beat 0.
- Saturation: force stall_cycles to 0xFFFFFFFE and stall for 3 cycles. Required: stall_cycles reads 0xFFFFFFFF and stays there. items_sent forced to 0xFFFFFFFF wraps to 0 after one item.
